// File: rtl/ifu_inst_queue.sv
// Instruction queue between fetch and decode.
// Registered-state handshakes; empty head reads as a NOP.
module ifu_inst_queue #(
    parameter int DEPTH           = 4,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int CU_BUS_WIDTH    = 4,
    parameter int CU_FLUSH        = 0,
    parameter int CU_STALL        = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [INST_ADDR_WIDTH-1:0] old_pc_i,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    input  logic [CU_BUS_WIDTH-1:0]    stall_flag_i,
    output logic [31:0]                inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic [INST_ADDR_WIDTH-1:0] old_pc_o,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   NOP  = 32'h0000_0013;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]                inst_mem [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] opc_mem  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          flush;
    logic          stall;
    logic          push;
    logic          pop;
    logic          unused_cu_bits;

    assign flush = stall_flag_i[CU_FLUSH];
    assign stall = stall_flag_i[CU_STALL];
    assign unused_cu_bits = ^stall_flag_i;

    assign inst_ready_o = (count < FULL);
    assign inst_valid_o = (count != '0);
    assign count_o      = count;

    assign push = inst_valid_i & inst_ready_o & ~flush;
    assign pop  = inst_valid_o & inst_ready_i & ~stall & ~flush;

    // Power-of-two depth: pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= inst_addr_i;
            opc_mem[wr_ptr]  <= old_pc_i;
        end
    end

    assign inst_o      = inst_valid_o ? inst_mem[rd_ptr] : NOP;
    assign inst_addr_o = inst_valid_o ? addr_mem[rd_ptr] : '0;
    assign old_pc_o    = inst_valid_o ? opc_mem[rd_ptr]  : '0;

endmodule
